// File: rtl/spi_csr_pkg.sv
// Shared constants and types for the SPI-attached CSR block: register
// addresses, default ID value and the FSM state encoding.
package spi_csr_pkg;

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_CTRL    = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH = 3'd4;

  localparam logic [7:0] ID_DEFAULT = 8'hC5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CMD  = 2'd1;
  localparam state_t ST_DATA = 2'd2;

endpackage

// File: rtl/spi_csr_if.sv
// SPI bus bundle: the master drives chip select, clock and MOSI, the
// slave (spi_csr) drives MISO.
interface spi_csr_if;
  logic spi_cs;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs, output spi_sck, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs, input spi_sck, input spi_mosi, output spi_miso);
endinterface

// File: rtl/dff_sync.sv
// Multi-flop synchronizer cell for a single asynchronous input bit.
module dff_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_csr.sv
// SPI mode-0 slave giving access to a small CSR file (ID, STATUS, CTRL,
// MODE, SCRATCH). All SPI pins are synchronized into clk; SCK edges are
// detected in the clk domain.
// Optional feature macro: SPI_CSR_AUTOINC_EN -- when defined the address
// advances modulo 8 after every completed data byte of a frame.
module spi_csr
  import spi_csr_pkg::*;
#(
  parameter logic [7:0] ID_VALUE    = ID_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  spi_csr_if.slave   spi,
  input  logic [7:0] status,
  output logic [7:0] csr_ctrl,
  output logic [7:0] csr_mode,
  output logic       csr_wr_strobe,
  output logic [2:0] csr_wr_addr
);

  // A single-flop "synchronizer" is not metastability-safe; clamp to 2.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic cs_s, sck_s, mosi_s;

  // CS synchronizer resets low so that a CS already held low when reset
  // releases is not mistaken for a new falling edge.
  dff_sync #(.STAGES(SYNC_N), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(spi.spi_cs), .q_o(cs_s)
  );
  dff_sync #(.STAGES(SYNC_N), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d_i(spi.spi_sck), .q_o(sck_s)
  );
  dff_sync #(.STAGES(SYNC_N), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(spi.spi_mosi), .q_o(mosi_s)
  );

  logic       cs_d_q, sck_d_q;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [2:0] addr_q, addr_d;
  logic       rd_q, rd_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] scratch_q, scratch_d;
  logic [2:0] wr_addr_q, wr_addr_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       miso_q, miso_d;

  logic       sck_rise_s, sck_fall_s, cs_fall_s;
  logic [7:0] rx_shift_s;
  logic [2:0] addr_next_s;
  logic [2:0] rd_addr_s;
  logic [7:0] rd_mux_s;

  assign sck_rise_s = sck_s & ~sck_d_q;
  assign sck_fall_s = ~sck_s & sck_d_q;
  assign cs_fall_s  = ~cs_s & cs_d_q;
  assign rx_shift_s = {rx_sr_q[6:0], mosi_s};

`ifdef SPI_CSR_AUTOINC_EN
  assign addr_next_s = addr_q + 3'd1;
`else
  assign addr_next_s = addr_q;
`endif

  // The command byte selects the first read address; later bytes use the
  // frame address (advanced when auto-increment is enabled).
  assign rd_addr_s = (state_q == ST_CMD) ? rx_shift_s[2:0] : addr_next_s;

  // Register read multiplexer; STATUS is sampled live at capture time.
  always_comb begin
    rd_mux_s = 8'h00;
    case (rd_addr_s)
      ADDR_ID:      rd_mux_s = ID_VALUE;
      ADDR_STATUS:  rd_mux_s = status;
      ADDR_CTRL:    rd_mux_s = ctrl_q;
      ADDR_MODE:    rd_mux_s = mode_q;
      ADDR_SCRATCH: rd_mux_s = scratch_q;
      default:      rd_mux_s = 8'h00;
    endcase
  end

  // Frame FSM, shift registers and register-file next state.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    ctrl_d      = ctrl_q;
    mode_d      = mode_q;
    scratch_d   = scratch_q;
    wr_addr_d   = wr_addr_q;
    wr_strobe_d = 1'b0;
    if (cs_s) begin
      // Deselect aborts whatever is in flight; a partial byte is dropped.
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      rx_sr_d   = 8'h00;
      tx_sr_d   = 8'h00;
      rd_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
            rx_sr_d   = 8'h00;
            tx_sr_d   = 8'h00;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (sck_rise_s) begin
            rx_sr_d   = rx_shift_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_DATA;
              rd_d    = rx_shift_s[7];
              addr_d  = rx_shift_s[2:0];
              if (rx_shift_s[7]) begin
                tx_sr_d = rd_mux_s;
              end else begin
                tx_sr_d = 8'h00;
              end
            end else begin
              state_d = ST_CMD;
            end
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_DATA: begin
          if (sck_rise_s) begin
            rx_sr_d   = rx_shift_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d = addr_next_s;
              if (rd_q) begin
                tx_sr_d = rd_mux_s;
              end else begin
                tx_sr_d     = 8'h00;
                wr_addr_d   = addr_q;
                wr_strobe_d = 1'b1;
                case (addr_q)
                  ADDR_CTRL:    ctrl_d    = rx_shift_s;
                  ADDR_MODE:    mode_d    = rx_shift_s;
                  ADDR_SCRATCH: scratch_d = rx_shift_s;
                  default:      ctrl_d    = ctrl_q;
                endcase
              end
            end else begin
              state_d = ST_DATA;
            end
          end else if (sck_fall_s && rd_q && (bit_cnt_q != 3'd0)) begin
            // The falling edge right after a byte boundary must keep the
            // freshly loaded MSB on the line for the master's next sample.
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end else begin
            state_d = ST_DATA;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    if ((state_d == ST_DATA) && rd_d) begin
      miso_d = tx_sr_d[7];
    end else begin
      miso_d = 1'b0;
    end
  end

  // State and register update with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_d_q      <= 1'b0;
      sck_d_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'h00;
      addr_q      <= 3'd0;
      rd_q        <= 1'b0;
      ctrl_q      <= 8'h00;
      mode_q      <= 8'h00;
      scratch_q   <= 8'h00;
      wr_addr_q   <= 3'd0;
      wr_strobe_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      cs_d_q      <= cs_s;
      sck_d_q     <= sck_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      ctrl_q      <= ctrl_d;
      mode_q      <= mode_d;
      scratch_q   <= scratch_d;
      wr_addr_q   <= wr_addr_d;
      wr_strobe_q <= wr_strobe_d;
      miso_q      <= miso_d;
    end
  end

  assign csr_ctrl      = ctrl_q;
  assign csr_mode      = mode_q;
  assign csr_wr_strobe = wr_strobe_q;
  assign csr_wr_addr   = wr_addr_q;
  assign spi.spi_miso  = miso_q;

endmodule

// File: tb/tb_spi_csr.sv
// Directed bench for spi_csr: an SPI master at f_clk/8 drives frames, a
// queue holds the expected values pushed with each stimulus step.
module tb_spi_csr;
  import spi_csr_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] status;
  logic [7:0] csr_ctrl;
  logic [7:0] csr_mode;
  logic       csr_wr_strobe;
  logic [2:0] csr_wr_addr;

  spi_csr_if spi_bus ();

  spi_csr dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (spi_bus.slave),
    .status       (status),
    .csr_ctrl     (csr_ctrl),
    .csr_mode     (csr_mode),
    .csr_wr_strobe(csr_wr_strobe),
    .csr_wr_addr  (csr_wr_addr)
  );

  int checks   = 0;
  int failures = 0;
  int strobe_cnt = 0;
  logic [7:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (csr_wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift nbits of tx (MSB first); rx collects MISO sampled at each rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic [7:0] t;
    t  = tx;
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_bus.spi_mosi = t[7];
      t = {t[6:0], 1'b0};
      #40;
      rx = {rx[6:0], spi_bus.spi_miso};
      spi_bus.spi_sck = 1'b1;
      #40;
      spi_bus.spi_sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    spi_bus.spi_cs = 1'b0;
    #80;
  endtask

  task automatic frame_end();
    #80;
    spi_bus.spi_cs = 1'b1;
    #80;
  endtask

  task automatic write_frame(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] rx;
    frame_begin();
    spi_bits(cmd, 8, rx);
    spi_bits(data, 8, rx);
    chk("miso_wr_data", {24'h0, rx}, 32'h0);
    frame_end();
  endtask

  // Reads nbytes; each byte is compared with the next queued expectation.
  task automatic read_frame(input string tag, input logic [7:0] cmd, input int nbytes);
    logic [7:0] rx;
    logic [7:0] exp;
    frame_begin();
    spi_bits(cmd, 8, rx);
    chk("miso_cmd", {24'h0, rx}, 32'h0);
    for (int b = 0; b < nbytes; b++) begin
      spi_bits(8'h00, 8, rx);
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else exp = 8'hxx;
      chk(tag, {24'h0, rx}, {24'h0, exp});
    end
    frame_end();
    chk("miso_idle", {31'h0, spi_bus.spi_miso}, 32'h0);
  endtask

  initial begin
    int s0;
    logic [7:0] rx;
    rst = 1'b1;
    status = 8'h00;
    spi_bus.spi_cs = 1'b1;
    spi_bus.spi_sck = 1'b0;
    spi_bus.spi_mosi = 1'b0;
    #20;
    chk("rst_ctrl", {24'h0, csr_ctrl}, 32'h0);
    chk("rst_mode", {24'h0, csr_mode}, 32'h0);
    chk("rst_wr_addr", {29'h0, csr_wr_addr}, 32'h0);
    chk("rst_strobe", {31'h0, csr_wr_strobe}, 32'h0);
    chk("rst_miso", {31'h0, spi_bus.spi_miso}, 32'h0);
    #10;
    rst = 1'b0;
    #100;

    // Write CTRL
    exp_q.push_back(8'hA5);
    s0 = strobe_cnt;
    write_frame(8'h02, 8'hA5);
    chk("wr_ctrl", {24'h0, csr_ctrl}, {24'h0, exp_q.pop_front()});
    chk("wr_ctrl_strobes", strobe_cnt - s0, 1);
    chk("wr_ctrl_addr", {29'h0, csr_wr_addr}, 32'd2);

    // Read ID and STATUS
    exp_q.push_back(8'hC5);
    read_frame("rd_id", 8'h80, 1);
    status = 8'h03;
    exp_q.push_back(8'h03);
    read_frame("rd_status", 8'h81, 1);

    // SCRATCH round trip
    write_frame(8'h04, 8'h3C);
    exp_q.push_back(8'h3C);
    read_frame("rd_scratch", 8'h84, 1);

    // Write to read-only ID: strobe still fires, value unchanged
    s0 = strobe_cnt;
    write_frame(8'h00, 8'hFF);
    chk("wr_id_strobes", strobe_cnt - s0, 1);
    chk("wr_id_addr", {29'h0, csr_wr_addr}, 32'd0);
    exp_q.push_back(8'hC5);
    read_frame("rd_id_after_wr", 8'h80, 1);

    // Unmapped address: writes ignored, reads zero
    write_frame(8'h06, 8'hAB);
    chk("wr_unmapped_addr", {29'h0, csr_wr_addr}, 32'd6);
    exp_q.push_back(8'h00);
    read_frame("rd_unmapped", 8'h86, 1);

    // CS released after 5 bits of a data byte
    s0 = strobe_cnt;
    frame_begin();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h5A, 5, rx);
    frame_end();
    chk("partial_mode", {24'h0, csr_mode}, 32'h0);
    chk("partial_strobes", strobe_cnt - s0, 0);

    // Multi-byte write frame
    s0 = strobe_cnt;
    frame_begin();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    spi_bits(8'h33, 8, rx);
    frame_end();
    chk("multi_strobes", strobe_cnt - s0, 3);
`ifdef SPI_CSR_AUTOINC_EN
    chk("multi_ctrl", {24'h0, csr_ctrl}, 32'h11);
    chk("multi_mode", {24'h0, csr_mode}, 32'h22);
    exp_q.push_back(8'h33);
    read_frame("multi_scratch", 8'h84, 1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    read_frame("multi_rd", 8'h82, 2);
`else
    chk("multi_ctrl", {24'h0, csr_ctrl}, 32'h33);
    chk("multi_mode", {24'h0, csr_mode}, 32'h00);
    exp_q.push_back(8'h3C);
    read_frame("multi_scratch", 8'h84, 1);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h33);
    read_frame("multi_rd", 8'h82, 2);
`endif

    // Reset in the middle of a write frame
    write_frame(8'h02, 8'h55);
    chk("pre_rst_ctrl", {24'h0, csr_ctrl}, 32'h55);
    s0 = strobe_cnt;
    frame_begin();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h77, 4, rx);
    rst = 1'b1;
    #20;
    chk("midrst_ctrl", {24'h0, csr_ctrl}, 32'h0);
    chk("midrst_mode", {24'h0, csr_mode}, 32'h0);
    chk("midrst_miso", {31'h0, spi_bus.spi_miso}, 32'h0);
    rst = 1'b0;
    #40;
    spi_bits(8'h70, 4, rx);
    spi_bits(8'h77, 8, rx);
    frame_end();
    chk("postrst_mode", {24'h0, csr_mode}, 32'h0);
    chk("postrst_strobes", strobe_cnt - s0, 0);
    exp_q.push_back(8'h00);
    read_frame("postrst_scratch", 8'h84, 1);
    s0 = strobe_cnt;
    write_frame(8'h03, 8'h77);
    chk("postrst_wr_mode", {24'h0, csr_mode}, 32'h77);
    chk("postrst_wr_strobes", strobe_cnt - s0, 1);
    chk("postrst_wr_addr", {29'h0, csr_wr_addr}, 32'd3);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
